video_frontend_conditioner: RTL and testbench

//  Conditions raw AD9226 composite samples before sync_separator and the ping-pong write path.

---
 rtl/video_frontend_conditioner_pkg.sv | 14 +
 rtl/video_frontend_conditioner_if.sv | 32 +++
 rtl/video_frontend_conditioner_boxcar_avg4.sv | 42 ++++
 rtl/video_frontend_conditioner.sv | 177 +++++++++++++++++
 tb/tb_video_frontend_conditioner.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/video_frontend_conditioner_pkg.sv
// Shared types and widths for the composite-video front-end conditioner.
package video_frontend_conditioner_pkg;

    localparam int ADC_W  = 12;
    localparam int LUMA_W = 8;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        ACCUM,
        UPDATE
    } lvl_state_t;

endpackage

// File: rtl/video_frontend_conditioner_if.sv
// Sample-in / conditioned-stream-out bundle between the ADC capture and the conditioner.
interface video_frontend_conditioner_if
    import video_frontend_conditioner_pkg::*;
#(
    parameter int DATA_W = ADC_W
);

    logic              sample_valid;
    logic [DATA_W-1:0] adc_in;
    logic              h_sync_pulse;
    logic              filt_valid;
    logic [DATA_W-1:0] filt_data;
    logic              luma_valid;
    logic [LUMA_W-1:0] luma;
    logic [DATA_W-1:0] black_level;
    logic [DATA_W-1:0] sync_tip;
    logic              level_valid;
    logic              timeout;

    modport master (
        output sample_valid, adc_in, h_sync_pulse,
        input  filt_valid, filt_data, luma_valid, luma,
        input  black_level, sync_tip, level_valid, timeout
    );

    modport slave (
        input  sample_valid, adc_in, h_sync_pulse,
        output filt_valid, filt_data, luma_valid, luma,
        output black_level, sync_tip, level_valid, timeout
    );

endinterface

// File: rtl/video_frontend_conditioner_boxcar_avg4.sv
// 4-tap boxcar average of the raw ADC stream; output is valid one clock after each strobe.
module boxcar_avg4
    import video_frontend_conditioner_pkg::*;
#(
    parameter int DATA_W = ADC_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_in,
    output logic              filt_valid,
    output logic [DATA_W-1:0] filt_data
);

    localparam int SUM_W = DATA_W + 2;

    logic [3:0][DATA_W-1:0] taps_p1;
    logic                   vld_p1;
    logic [SUM_W-1:0]       sum_p1;

    // p0 -> p1: tap shift on each strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= sample_valid;
            if (sample_valid)
                taps_p1 <= {taps_p1[2:0], adc_in};
        end
    end

    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < 4; i++)
            sum_p1 = sum_p1 + SUM_W'(taps_p1[i]);
    end

    assign filt_valid = vld_p1;
    assign filt_data  = DATA_W'(sum_p1 >> 2);

endmodule

// File: rtl/video_frontend_conditioner.sv
// Composite front end: boxcar filter, per-line back-porch/sync-tip measurement,
// black-clamped 8-bit luma, and a missing-sync watchdog.
module video_frontend_conditioner
    import video_frontend_conditioner_pkg::*;
#(
    parameter int                DATA_W       = ADC_W,
    parameter int                BP_START     = 24,
    parameter int                BP_LEN_LOG2  = 4,
    parameter int                LINE_TIMEOUT = 4096,
    parameter logic [DATA_W-1:0] BLACK_INIT   = 'h200,
    parameter int                LUMA_SHIFT   = 2
)(
    input logic                          clk,
    input logic                          rst_n,
    video_frontend_conditioner_if.slave  bus
);

    localparam int WIN   = 2 ** BP_LEN_LOG2;
    localparam int ACC_W = DATA_W + BP_LEN_LOG2;
    localparam int CNT_W = $clog2((BP_START > WIN) ? BP_START : WIN);
    localparam int CTR_W = $clog2(LINE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  SKIP_LAST = CNT_W'(BP_START - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN - 1);
    localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(LINE_TIMEOUT - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX   = CTR_W'(LINE_TIMEOUT);
    localparam logic [DATA_W-1:0] TIP_INIT  = '1;

    function automatic logic [LUMA_W-1:0] luma_sat(input logic signed [DATA_W:0] diff);
        logic signed [DATA_W:0] scaled;
        scaled = diff >>> LUMA_SHIFT;
        if (diff < 0)
            return '0;
        if (scaled > $signed((DATA_W+1)'(2 ** LUMA_W - 1)))
            return '1;
        return LUMA_W'(scaled);
    endfunction

    logic                   vld_p1;
    logic [DATA_W-1:0]      filt_p1;
    logic signed [DATA_W:0] diff_p1;
    logic                   vld_p2;
    logic [LUMA_W-1:0]      luma_p2;

    lvl_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [DATA_W-1:0] black_level, black_nxt;
    logic              level_valid, lvl_vld_nxt;
    logic [DATA_W-1:0] sync_tip, tip_nxt;
    logic [DATA_W-1:0] line_min, min_nxt;
    logic [CTR_W-1:0]  line_ctr, ctr_nxt;
    logic              timeout, timeout_nxt;

    boxcar_avg4 #(.DATA_W(DATA_W)) u_boxcar (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (bus.sample_valid),
        .adc_in       (bus.adc_in),
        .filt_valid   (vld_p1),
        .filt_data    (filt_p1)
    );

    assign diff_p1 = $signed({1'b0, filt_p1}) - $signed({1'b0, black_level});

    // p1 -> p2: black clamp and saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            luma_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                luma_p2 <= luma_sat(diff_p1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SYNC;
            cnt         <= '0;
            acc         <= '0;
            black_level <= BLACK_INIT;
            level_valid <= 1'b0;
            sync_tip    <= TIP_INIT;
            line_min    <= TIP_INIT;
            line_ctr    <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            acc         <= acc_nxt;
            black_level <= black_nxt;
            level_valid <= lvl_vld_nxt;
            sync_tip    <= tip_nxt;
            line_min    <= min_nxt;
            line_ctr    <= ctr_nxt;
            timeout     <= timeout_nxt;
        end
    end

    // UPDATE always commits, then a coincident sync pulse opens the new line, and
    // only then is a coincident filtered sample accounted to that new line.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        black_nxt   = black_level;
        lvl_vld_nxt = level_valid;
        tip_nxt     = sync_tip;
        min_nxt     = line_min;
        ctr_nxt     = line_ctr;
        timeout_nxt = timeout;

        if (state == UPDATE) begin
            black_nxt   = DATA_W'(acc >> BP_LEN_LOG2);
            lvl_vld_nxt = 1'b1;
            state_nxt   = WAIT_SYNC;
        end

        if (bus.h_sync_pulse) begin
            tip_nxt     = line_min;
            min_nxt     = TIP_INIT;
            ctr_nxt     = '0;
            timeout_nxt = 1'b0;
            state_nxt   = SKIP;
            cnt_nxt     = '0;
            acc_nxt     = '0;
        end

        if (vld_p1) begin
            if (filt_p1 < min_nxt)
                min_nxt = filt_p1;

            case (state_nxt)
                SKIP: begin
                    if (cnt_nxt == SKIP_LAST) begin
                        state_nxt = ACCUM;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_nxt + CNT_W'(1);
                    end
                end
                ACCUM: begin
                    acc_nxt = acc_nxt + ACC_W'(filt_p1);
                    if (cnt_nxt == WIN_LAST)
                        state_nxt = UPDATE;
                    else
                        cnt_nxt = cnt_nxt + CNT_W'(1);
                end
                default: ;
            endcase

            // Watchdog fires once on reaching the limit; the counter then saturates.
            if (ctr_nxt == CTR_LAST) begin
                timeout_nxt = 1'b1;
                lvl_vld_nxt = 1'b0;
                state_nxt   = WAIT_SYNC;
                cnt_nxt     = '0;
                acc_nxt     = '0;
            end
            if (ctr_nxt != CTR_MAX)
                ctr_nxt = ctr_nxt + CTR_W'(1);
        end
    end

    assign bus.filt_valid  = vld_p1;
    assign bus.filt_data   = filt_p1;
    assign bus.luma_valid  = vld_p2;
    assign bus.luma        = luma_p2;
    assign bus.black_level = black_level;
    assign bus.sync_tip    = sync_tip;
    assign bus.level_valid = level_valid;
    assign bus.timeout     = timeout;

endmodule

// File: tb/tb_video_frontend_conditioner.sv
// Bench for video_frontend_conditioner: directed line scenarios with random noise,
// checked against a sample-ordered reference model of the line measurements.
module tb_video_frontend_conditioner;
    import video_frontend_conditioner_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_frontend_conditioner_if #(.DATA_W(ADC_W)) bus();

    video_frontend_conditioner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state, expressed per sample position within a line
    int   m_taps [4];
    int   m_black, m_tip, m_line_min;
    bit   m_level_valid, m_timeout, m_armed;
    int   m_pos, m_acc, m_lc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int luma_ref(input int f, input int b);
        int d;
        d = f - b;
        if (d < 0) return 0;
        d = d / 4;
        return (d > 255) ? 255 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_taps[i] = 0;
        m_black = 'h200; m_tip = 'hFFF; m_line_min = 'hFFF;
        m_level_valid = 0; m_timeout = 0; m_armed = 0;
        m_pos = 0; m_acc = 0; m_lc = 0;
    endtask

    // Back porch = mean of filtered samples at line positions 24..39, measured once per line.
    task automatic model_sample(input int adc, input bit pulse, output int f, output int l);
        if (pulse) begin
            m_tip = m_line_min; m_line_min = 'hFFF;
            m_pos = 0; m_lc = 0; m_timeout = 0; m_armed = 1; m_acc = 0;
        end
        m_taps[3] = m_taps[2]; m_taps[2] = m_taps[1]; m_taps[1] = m_taps[0]; m_taps[0] = adc;
        f = (m_taps[0] + m_taps[1] + m_taps[2] + m_taps[3]) / 4;
        l = luma_ref(f, m_black);
        if (f < m_line_min) m_line_min = f;
        if (m_armed && m_pos >= 24) m_acc += f;
        if (m_armed && m_pos == 39) begin
            m_black = m_acc / 16; m_level_valid = 1; m_armed = 0;
        end
        m_pos++;
        if (m_lc < 4096) begin
            m_lc++;
            if (m_lc == 4096) begin
                m_timeout = 1; m_level_valid = 0; m_armed = 0;
            end
        end
    endtask

    task automatic do_sample(input int adc, input bit pulse);
        int ef, el;
        model_sample(adc, pulse, ef, el);
        bus.sample_valid = 1'b1;
        bus.adc_in       = 12'(adc);
        bus.h_sync_pulse = pulse;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.h_sync_pulse = 1'b0;
        bus.adc_in       = 12'($urandom);
        check("filt_valid", 32'(bus.filt_valid), 32'd1);
        check("filt_data", 32'(bus.filt_data), 32'(ef));
        @(posedge clk); #1;
        check("filt_valid_pulse", 32'(bus.filt_valid), 32'd0);
        check("luma_valid", 32'(bus.luma_valid), 32'd1);
        check("luma", 32'(bus.luma), 32'(el));
    endtask

    task automatic feed_line(input int tip, input int porch, input int active,
                             input int len, input int noise);
        for (int p = 0; p < len; p++) begin
            int v;
            v = (p < 8) ? tip : ((p < 44) ? porch : active);
            if (noise > 0) v += int'($urandom_range(noise));
            if (v > 4095) v = 4095;
            do_sample(v, p == 0);
        end
    endtask

    task automatic check_levels();
        repeat (3) begin @(posedge clk); #1; end
        check("idle_filt_valid", 32'(bus.filt_valid), 32'd0);
        check("idle_luma_valid", 32'(bus.luma_valid), 32'd0);
        check("black_level", 32'(bus.black_level), 32'(m_black));
        check("sync_tip", 32'(bus.sync_tip), 32'(m_tip));
        check("level_valid", 32'(bus.level_valid), 32'(m_level_valid));
        check("timeout", 32'(bus.timeout), 32'(m_timeout));
    endtask

    task automatic check_reset();
        check("rst_filt_valid", 32'(bus.filt_valid), 32'd0);
        check("rst_filt_data", 32'(bus.filt_data), 32'd0);
        check("rst_luma_valid", 32'(bus.luma_valid), 32'd0);
        check("rst_luma", 32'(bus.luma), 32'd0);
        check("rst_black", 32'(bus.black_level), 32'h200);
        check("rst_tip", 32'(bus.sync_tip), 32'hFFF);
        check("rst_level_valid", 32'(bus.level_valid), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        int saved_black;
        bus.sample_valid = 1'b0;
        bus.adc_in       = '0;
        bus.h_sync_pulse = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // Reset held while the strobe toggles
        for (int i = 0; i < 6; i++) begin
            bus.sample_valid = ((i % 2) == 0);
            bus.adc_in       = 12'($urandom);
            @(posedge clk); #1;
            check_reset();
        end
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant input: zero taps flush out over the first three outputs
        repeat (6) do_sample('h400, 1'b0);
        check_levels();

        // Clean synthetic line
        feed_line('h080, 'h300, 'hA00, 60, 0);
        check_levels();
        check("t3_black", 32'(bus.black_level), 32'h300);
        check("t3_level_valid", 32'(bus.level_valid), 32'd1);

        // Sync arrives mid-window: line of 32 samples, next pulse lands on window sample 8
        saved_black = m_black;
        feed_line('h100, 'h280, 'h800, 32, 0);
        check("t4_tip", 32'(bus.sync_tip), 32'h080);
        check("t4_black_held", 32'(bus.black_level), 32'(saved_black));
        feed_line('h100, 'h280, 'h800, 50, 0);
        check_levels();
        check("t4_black_new", 32'(bus.black_level), 32'h280);

        // 40-sample line: next pulse coincides with the UPDATE cycle
        feed_line('h050, 'h340, 'h600, 40, 0);
        feed_line('h380, 'h1C0, 'h700, 50, 0);
        check_levels();

        // Randomized lines with noise
        for (int n = 0; n < 6; n++) begin
            feed_line(int'($urandom_range(300)), int'($urandom_range(1200, 300)),
                      int'($urandom_range(4095)), int'($urandom_range(90, 40)),
                      int'($urandom_range(31)));
            check_levels();
        end

        // Watchdog: 4095 samples since the pulse is still in range, the 4096th trips it
        feed_line('h060, 'h2C0, 'h900, 4095, 15);
        check_levels();
        saved_black = m_black;
        do_sample(int'($urandom_range(4095)), 1'b0);
        check_levels();
        check("t5_timeout", 32'(bus.timeout), 32'd1);
        check("t5_level_valid", 32'(bus.level_valid), 32'd0);
        check("t5_black_held", 32'(bus.black_level), 32'(saved_black));
        feed_line('h070, 'h310, 'hB00, 45, 7);
        check_levels();
        check("t5_timeout_clr", 32'(bus.timeout), 32'd0);
        check("t5_relevel", 32'(bus.level_valid), 32'd1);

        // Asynchronous reset in the middle of the accumulation window
        feed_line('h040, 'h200, 'h900, 30, 3);
        #2 rst_n = 1'b0;
        #1 check_reset();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) do_sample(int'($urandom_range(4095)), 1'b0);
        check_levels();
        check("t6_no_update", 32'(bus.level_valid), 32'd0);
        feed_line('h040, 'h240, 'h900, 45, 3);
        check_levels();
        check("t6_update", 32'(bus.level_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
